rca_pipe: RTL and testbench

Parametrised, pipelined ripple-carry adder: successor to the fixed 32-bit combinational `rca32`. Splits a WIDTH-bit add into STAGES equal slices, one slice per pipeline stage, with carry registered between stages. Adds a valid/ready handshake with full-pipeline stall, so it sits directly in the ALU datapath at one result per cycle with bounded critical path.

---
 rtl/rca_pipe.sv | 85 ++++++++
 tb/tb_rca_pipe.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rca_pipe.sv
// rca_pipe: STAGES-deep pipelined ripple-carry adder with valid/ready and full-pipeline stall.
// Define RCA_PIPE_OVF_EN to compute signed overflow; otherwise ovf is tied to 0.
module rca_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int W_S = WIDTH / STAGES;
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * W_S;
    // w_ua/w_ub: operand bits not yet summed, current slice in the low W_S bits
    logic [WIDTH-LO-1:0] w_ua, w_ub;
    logic                w_ci, w_vi;
    logic [W_S:0]        w_add;
    logic                r_v, r_c;
    logic [LO+W_S-1:0]   r_s;
    if (k == 0) begin : g_in
      assign w_ua = a;
      assign w_ub = b;
      assign w_ci = cin;
      assign w_vi = in_valid;
      always_ff @(posedge clk)
        if (rst) r_s <= '0;
        else if (w_adv) r_s <= w_add[W_S-1:0];
    end else begin : g_in
      assign w_ua = g_st[k-1].g_up.r_a;
      assign w_ub = g_st[k-1].g_up.r_b;
      assign w_ci = g_st[k-1].r_c;
      assign w_vi = g_st[k-1].r_v;
      always_ff @(posedge clk)
        if (rst) r_s <= '0;
        else if (w_adv) r_s <= {w_add[W_S-1:0], g_st[k-1].r_s};
    end
    if (k < STAGES - 1) begin : g_up
      logic [WIDTH-LO-W_S-1:0] r_a, r_b;
      always_ff @(posedge clk)
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_ua[WIDTH-LO-1:W_S];
          r_b <= w_ub[WIDTH-LO-1:W_S];
        end
    end
    assign w_add = {1'b0, w_ua[W_S-1:0]} + {1'b0, w_ub[W_S-1:0]} + {{W_S{1'b0}}, w_ci};
    always_ff @(posedge clk)
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_vi;
        r_c <= w_add[W_S];
      end
  end
  assign out_valid = g_st[STAGES-1].r_v;
  assign sum       = g_st[STAGES-1].r_s;
  assign cout      = g_st[STAGES-1].r_c;
`ifdef RCA_PIPE_OVF_EN
  logic w_am, w_bm, w_sm, r_ovf;
  assign w_am = g_st[STAGES-1].w_ua[W_S-1];
  assign w_bm = g_st[STAGES-1].w_ub[W_S-1];
  assign w_sm = g_st[STAGES-1].w_add[W_S-1];
  always_ff @(posedge clk)
    if (rst) r_ovf <= 1'b0;
    else if (w_adv) r_ovf <= (w_am == w_bm) && (w_sm != w_am);
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: randomized scoreboard bench for rca_pipe (32x4 directed/random plus a parameter sweep).
module tb_rca_pipe;
  localparam int W = 32, S = 4;
  localparam int SW [3] = '{8, 16, 64};
  localparam int SS [3] = '{1, 16, 8};
  typedef struct { logic [65:0] v; int t; int st; } tok_t;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 1;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] a = 0, b = 0, sum;
  int n_chk = 0, n_pass = 0, cyc = 0, stalls = 0;
  bit drain = 0, done = 0, acc = 0, rst_pend = 0;
  tok_t q[$];
  always #5 clk = ~clk;
  rca_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));
  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // expected {ovf, cout, sum} for a w-bit add
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] x, input logic [63:0] y, input logic c);
    logic [64:0] f;
    logic o;
    f = {1'b0, x} + {1'b0, y} + 65'(c);
`ifdef RCA_PIPE_OVF_EN
    o = (x[w-1] == y[w-1]) && (f[w-1] != x[w-1]);
`else
    o = 1'b0;
`endif
    return (66'(f) & ((66'(1) << w) - 66'(1))) | (66'(f[w]) << w) | (66'(o) << (w + 1));
  endfunction
  task automatic mon();
    cyc++;
    acc = 0;
    if (rst_pend) begin
      check("rst_valid", 66'(out_valid), 66'(0));
      check("rst_data", 66'({ovf, cout, sum}), 66'(0));
      check("rst_ready", 66'(in_ready), 66'(1));
      rst_pend = 0;
    end
    check("in_ready", 66'(in_ready), 66'(!out_valid || out_ready));
    if (out_valid) begin
      if (q.size() == 0) check("spurious", 66'(out_valid), 66'(0));
      else begin
        check("data", 66'({ovf, cout, sum}), q[0].v);
        if (out_ready) begin
          check("latency", 66'(cyc - q[0].t - (stalls - q[0].st)), 66'(S));
          void'(q.pop_front());
        end
      end
    end
    if (out_valid && !out_ready) stalls++;
    if (rst) begin
      q.delete();
      rst_pend = 1;
    end else if (in_valid && in_ready) begin
      q.push_back('{ref_add(W, 64'(a), 64'(b), cin), cyc, stalls});
      acc = 1;
    end
  endtask
  task automatic drv(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic r);
    in_valid = v; a = x; b = y; cin = c; out_ready = r;
    #1 mon();
    @(negedge clk);
  endtask
  for (genvar j = 0; j < 3; j++) begin : g_sw
    localparam int WJ = SW[j], SJ = SS[j];
    logic iv = 0, c = 0, orr = 1, ir, ov, co, of;
    logic [WJ-1:0] x = 0, y = 0, s;
    tok_t sq[$];
    int sc = 0, sst = 0;
    rca_pipe #(.WIDTH(WJ), .STAGES(SJ)) u (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(x), .b(y), .cin(c),
      .out_valid(ov), .out_ready(orr), .sum(s), .cout(co), .ovf(of));
    initial begin
      @(negedge clk);
      while (!done) begin
        iv = !drain && ($urandom_range(0, 3) != 0);
        x = WJ'({$urandom, $urandom});
        y = WJ'({$urandom, $urandom});
        c = 1'($urandom_range(0, 1));
        orr = drain || ($urandom_range(0, 4) != 0);
        #1 sc++;
        if (ov) begin
          if (sq.size() == 0) check($sformatf("sw%0d_spurious", WJ), 66'(ov), 66'(0));
          else begin
            check($sformatf("sw%0d_data", WJ), 66'({of, co, s}), sq[0].v);
            if (orr) begin
              check($sformatf("sw%0d_latency", WJ), 66'(sc - sq[0].t - (sst - sq[0].st)), 66'(SJ));
              void'(sq.pop_front());
            end
          end
        end
        if (ov && !orr) sst++;
        if (rst) sq.delete();
        else if (iv && ir) sq.push_back('{ref_add(WJ, 64'(x), 64'(y), c), sc, sst});
        @(negedge clk);
      end
      check($sformatf("sw%0d_drain", WJ), 66'(sq.size()), 66'(0));
    end
  end
  initial begin
    int i, c;
    @(negedge clk);
    repeat (2) drv(0, 0, 0, 0, 1);
    rst = 0;
    drv(1, 32'h00520112, 32'h00445566, 1, 1);
    repeat (3) drv(0, 0, 0, 0, 1);
    check("pulse_valid", 66'(out_valid), 66'(1));
    check("pulse_sum", 66'(sum), 66'(32'h00965679));
    check("pulse_cout", 66'(cout), 66'(0));
    check("pulse_ovf", 66'(ovf), 66'(0));
    drv(0, 0, 0, 0, 1);
    check("pulse_once", 66'(out_valid), 66'(0));
    drv(1, 32'hFFFFFFFF, 32'h0, 1, 1);
    drv(1, 32'h7FFFFFFF, 32'h1, 0, 1);
    repeat (2) drv(0, 0, 0, 0, 1);
    check("chain_sum", 66'({cout, sum}), {33'h0, 33'h100000000});
    check("chain_ovf", 66'(ovf), 66'(0));
    drv(0, 0, 0, 0, 1);
    check("max_sum", 66'({cout, sum}), 66'(32'h80000000));
`ifdef RCA_PIPE_OVF_EN
    check("max_ovf", 66'(ovf), 66'(1));
`else
    check("max_ovf", 66'(ovf), 66'(0));
`endif
    repeat (S) drv(0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) drv(1, 32'(k), 32'h1, 0, 1);
    repeat (S + 2) drv(0, 0, 0, 0, 1);
    i = 0;
    c = 0;
    while (i < 20 && c < 200) begin
      drv(1, 32'(i), 32'h1, 0, !(c >= 8 && c < 11));
      if (acc) i++;
      c++;
    end
    check("bp_accepted", 66'(i), 66'(20));
    repeat (S + 2) drv(0, 0, 0, 0, 1);
    repeat (3) drv(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1);
    rst = 1;
    drv(1, $urandom, $urandom, 0, 1);
    rst = 0;
    drv(1, 32'h12345678, 32'h11111111, 0, 1);
    repeat (S + 2) drv(0, 0, 0, 0, 1);
    repeat (400) drv(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    repeat (S + 4) drv(0, 0, 0, 0, 1);
    check("drain", 66'(q.size()), 66'(0));
    drain = 1;
    repeat (24) drv(0, 0, 0, 0, 1);
    done = 1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
